// File: rtl/fetch_queue.sv
// Instruction-fetch stage: owns the fetch PC, drives a 1-cycle-latency instruction
// memory and buffers returned instructions in a small FIFO toward decode.
module fetch_queue #(
    parameter int unsigned        ADDR_W   = 32,
    parameter int unsigned        DATA_W   = 32,
    parameter int unsigned        DEPTH    = 4,
    parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(32'h0000_3000)
) (
    input  logic                         clk,
    input  logic                         reset,
    output logic                         imem_req,
    output logic [ADDR_W-1:0]            imem_addr,
    input  logic [DATA_W-1:0]            imem_rdata,
    input  logic                         redirect,
    input  logic [ADDR_W-1:0]            redirect_pc,
    input  logic                         id_ready,
    output logic                         id_valid,
    output logic [DATA_W-1:0]            id_instr,
    output logic [ADDR_W-1:0]            id_pc,
    output logic [ADDR_W-1:0]            id_pc4,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [ADDR_W-1:0] fpc_q, fpc_d;
    logic              inflight_q, inflight_d;
    logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;

    logic [DATA_W-1:0] instr_mem_q [DEPTH];
    logic [ADDR_W-1:0] pc_mem_q    [DEPTH];

    logic              valid_c;
    logic              pop_c;
    logic              push_c;
    logic              issue_c;
    logic [CNT_W:0]    occupancy_c;

    // Handshake, credit check and next-state computation.
    always_comb begin
        valid_c       = !reset && (count_q != '0);
        pop_c         = valid_c && id_ready;
        push_c        = !reset && inflight_q && !redirect;
        occupancy_c   = {1'b0, count_q} + (CNT_W+1)'(inflight_q);
        issue_c       = !reset && !redirect &&
                        ((occupancy_c < (CNT_W+1)'(DEPTH)) || pop_c);

        fpc_d         = fpc_q;
        inflight_d    = issue_c;
        inflight_pc_d = inflight_pc_q;
        count_d       = count_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;

        if (issue_c) begin
            fpc_d         = fpc_q + ADDR_W'(4);
            inflight_pc_d = fpc_q;
        end

        if (redirect) begin
            fpc_d    = {redirect_pc[ADDR_W-1:2], 2'b00};
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            rd_ptr_d = rd_ptr_q + PTR_W'(pop_c);
            wr_ptr_d = wr_ptr_q + PTR_W'(push_c);
            count_d  = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
        end
    end

    // Control state.
    always_ff @(posedge clk) begin
        if (reset) begin
            fpc_q         <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            count_q       <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
        end else begin
            fpc_q         <= fpc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            count_q       <= count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
        end
    end

    // FIFO storage; contents need no reset since occupancy gates visibility.
    always_ff @(posedge clk) begin
        if (push_c) begin
            instr_mem_q[wr_ptr_q] <= imem_rdata;
            pc_mem_q[wr_ptr_q]    <= inflight_pc_q;
        end
    end

    // The credit rule must make a push into a full FIFO impossible.
    always_ff @(posedge clk) begin
        if (!reset && push_c && !pop_c) begin
            assert (count_q != CNT_W'(DEPTH))
                else $error("fetch_queue: push into full FIFO");
        end
    end

    always_comb begin
        imem_req  = issue_c;
        imem_addr = fpc_q;
        id_valid  = valid_c;
        id_instr  = valid_c ? instr_mem_q[rd_ptr_q] : '0;
        id_pc     = valid_c ? pc_mem_q[rd_ptr_q] : '0;
        id_pc4    = valid_c ? pc_mem_q[rd_ptr_q] + ADDR_W'(4) : '0;
        count     = reset ? '0 : count_q;
    end

endmodule
